// File: rtl/crypto_acc_host_master.sv
// Bus initiator that loads key/data into the crypto accelerator, starts it, polls STATUS and
// streams the result words out. Define CRYPTO_HOST_POLL_TIMEOUT_EN to abort after POLL_LIMIT polls.
module crypto_acc_host_master #(
  parameter int                   BUS_WIDTH    = 32,
  parameter logic [BUS_WIDTH-1:0] BASE_ADDRESS = 32'hF4000000,
  parameter int                   LEN_W        = 11,
  parameter int                   POLL_GAP     = 4,
  parameter int                   POLL_LIMIT   = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     key_len_i,
  input  logic [LEN_W-1:0]     data_len_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [BUS_WIDTH-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [BUS_WIDTH-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 bus_read_en_o,
  output logic                 bus_write_en_o,
  output logic [BUS_WIDTH-1:0] bus_addr_o,
  output logic [BUS_WIDTH-1:0] bus_data_o,
  input  logic [BUS_WIDTH-1:0] bus_data_i,
  output logic [3:0]           dbg_state_o
);
  // Handshakes: a word moves on in_*/out_* only in a cycle where valid and ready are both high;
  // valid never waits on ready, and the bus strobes are issued only in the cycle the word moves.
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WR_KLEN   = 4'd1;
  localparam logic [3:0] S_WR_KEY    = 4'd2;
  localparam logic [3:0] S_WR_DLEN   = 4'd3;
  localparam logic [3:0] S_WR_DATA   = 4'd4;
  localparam logic [3:0] S_WR_START  = 4'd5;
  localparam logic [3:0] S_POLL      = 4'd6;
  localparam logic [3:0] S_POLL_WAIT = 4'd7;
  localparam logic [3:0] S_GAP       = 4'd8;
  localparam logic [3:0] S_RD_RLEN   = 4'd9;
  localparam logic [3:0] S_RLEN_WAIT = 4'd10;
  localparam logic [3:0] S_RD_RES    = 4'd11;
  localparam logic [3:0] S_RES_WAIT  = 4'd12;
  localparam logic [3:0] S_RES_OUT   = 4'd13;
  localparam logic [3:0] S_DONE      = 4'd14;
  localparam logic [3:0] S_ERR       = 4'd15;

  localparam logic [BUS_WIDTH-1:0] OFF_CTRL   = BUS_WIDTH'('h0000);
  localparam logic [BUS_WIDTH-1:0] OFF_STATUS = BUS_WIDTH'('h0008);
  localparam logic [BUS_WIDTH-1:0] OFF_KLEN   = BUS_WIDTH'('h0104);
  localparam logic [BUS_WIDTH-1:0] OFF_DLEN   = BUS_WIDTH'('h0108);
  localparam logic [BUS_WIDTH-1:0] OFF_RLEN   = BUS_WIDTH'('h010C);
  localparam logic [BUS_WIDTH-1:0] OFF_KBUF   = BUS_WIDTH'('h4000);
  localparam logic [BUS_WIDTH-1:0] OFF_DBUF   = BUS_WIDTH'('h8000);
  localparam logic [BUS_WIDTH-1:0] OFF_RBUF   = BUS_WIDTH'('hC000);

  localparam int MAX_WORDS = 1024;
  localparam int GAP_W     = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int GAP_LAST  = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

  if (POLL_LIMIT < 1) begin : g_bad_poll_limit
    $error("POLL_LIMIT must be at least 1");
  end
  if (LEN_W < 11) begin : g_bad_len_w
    $error("LEN_W must hold a 1024-word count");
  end

  logic [3:0]           state_q, state_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     key_len_q, key_len_d;
  logic [LEN_W-1:0]     data_len_q, data_len_d;
  logic [LEN_W-1:0]     res_len_q, res_len_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [BUS_WIDTH-1:0] out_data_q, out_data_d;
  logic [BUS_WIDTH-1:0] idx_off;

`ifdef CRYPTO_HOST_POLL_TIMEOUT_EN
  localparam int PCNT_W = $clog2(POLL_LIMIT + 1);
  logic [PCNT_W-1:0] poll_cnt_q, poll_cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) poll_cnt_q <= '0;
    else       poll_cnt_q <= poll_cnt_d;
  end
`endif

  assign idx_off     = BUS_WIDTH'({idx_q, 2'b00});
  assign out_data_o  = out_data_q;
  assign dbg_state_o = state_q;
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    key_len_d      = key_len_q;
    data_len_d     = data_len_q;
    res_len_d      = res_len_q;
    gap_d          = gap_q;
    out_data_d     = out_data_q;
    in_ready_o     = 1'b0;
    out_valid_o    = 1'b0;
    out_last_o     = 1'b0;
    done_o         = 1'b0;
    err_o          = 1'b0;
    bus_read_en_o  = 1'b0;
    bus_write_en_o = 1'b0;
    bus_addr_o     = '0;
    bus_data_o     = '0;
`ifdef CRYPTO_HOST_POLL_TIMEOUT_EN
    poll_cnt_d     = poll_cnt_q;
`endif
    case (state_q)
      S_IDLE: if (start_i) begin
        key_len_d  = key_len_i;
        data_len_d = data_len_i;
        idx_d      = '0;
        state_d    = S_WR_KLEN;
      end
      S_WR_KLEN: begin
        bus_write_en_o = 1'b1;
        bus_addr_o     = BASE_ADDRESS + OFF_KLEN;
        bus_data_o     = BUS_WIDTH'(key_len_q);
        state_d        = (key_len_q == '0) ? S_WR_DLEN : S_WR_KEY;
      end
      S_WR_KEY: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          bus_write_en_o = 1'b1;
          bus_addr_o     = BASE_ADDRESS + OFF_KBUF + idx_off;
          bus_data_o     = in_data_i;
          if (idx_q == key_len_q - LEN_W'(1)) begin
            idx_d   = '0;
            state_d = S_WR_DLEN;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      S_WR_DLEN: begin
        bus_write_en_o = 1'b1;
        bus_addr_o     = BASE_ADDRESS + OFF_DLEN;
        bus_data_o     = BUS_WIDTH'(data_len_q);
        state_d        = (data_len_q == '0) ? S_WR_START : S_WR_DATA;
      end
      S_WR_DATA: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          bus_write_en_o = 1'b1;
          bus_addr_o     = BASE_ADDRESS + OFF_DBUF + idx_off;
          bus_data_o     = in_data_i;
          if (idx_q == data_len_q - LEN_W'(1)) begin
            idx_d   = '0;
            state_d = S_WR_START;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      S_WR_START: begin
        bus_write_en_o = 1'b1;
        bus_addr_o     = BASE_ADDRESS + OFF_CTRL;
        bus_data_o     = BUS_WIDTH'(1);
        state_d        = S_POLL;
`ifdef CRYPTO_HOST_POLL_TIMEOUT_EN
        poll_cnt_d     = '0;
`endif
      end
      S_POLL: begin
        bus_read_en_o = 1'b1;
        bus_addr_o    = BASE_ADDRESS + OFF_STATUS;
        state_d       = S_POLL_WAIT;
`ifdef CRYPTO_HOST_POLL_TIMEOUT_EN
        poll_cnt_d    = poll_cnt_q + PCNT_W'(1);
`endif
      end
      S_POLL_WAIT: begin
        gap_d = '0;
        if (bus_data_i[0]) state_d = S_RD_RLEN;
`ifdef CRYPTO_HOST_POLL_TIMEOUT_EN
        else if (poll_cnt_q == PCNT_W'(POLL_LIMIT)) state_d = S_ERR;
`endif
        else if (POLL_GAP == 0) state_d = S_POLL;
        else state_d = S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP_LAST)) state_d = S_POLL;
      end
      S_RD_RLEN: begin
        bus_read_en_o = 1'b1;
        bus_addr_o    = BASE_ADDRESS + OFF_RLEN;
        state_d       = S_RLEN_WAIT;
      end
      S_RLEN_WAIT: begin
        // The engine may report more than the result buffer holds; never read past it.
        res_len_d = (bus_data_i > BUS_WIDTH'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : LEN_W'(bus_data_i);
        idx_d     = '0;
        state_d   = (res_len_d == '0) ? S_DONE : S_RD_RES;
      end
      S_RD_RES: begin
        bus_read_en_o = 1'b1;
        bus_addr_o    = BASE_ADDRESS + OFF_RBUF + idx_off;
        state_d       = S_RES_WAIT;
      end
      S_RES_WAIT: begin
        out_data_d = bus_data_i;
        state_d    = S_RES_OUT;
      end
      S_RES_OUT: begin
        out_valid_o = 1'b1;
        out_last_o  = (idx_q == res_len_q - LEN_W'(1));
        if (out_ready_i) begin
          if (out_last_o) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = S_RD_RES;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
`ifdef CRYPTO_HOST_POLL_TIMEOUT_EN
      S_ERR: begin
        err_o          = 1'b1;
        bus_write_en_o = 1'b1;
        bus_addr_o     = BASE_ADDRESS + OFF_CTRL;
        state_d        = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      key_len_q  <= '0;
      data_len_q <= '0;
      res_len_q  <= '0;
      gap_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      key_len_q  <= key_len_d;
      data_len_q <= data_len_d;
      res_len_q  <= res_len_d;
      gap_q      <= gap_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_crypto_acc_host_master.sv
// Bench for crypto_acc_host_master: a behavioural accelerator slave plus a transaction-level
// model of the expected bus sequence and result stream, driven by a job table and random jobs.
module tb_crypto_acc_host_master;
  localparam int          POLL_GAP   = 4;
  localparam int          POLL_LIMIT = 16;
  localparam logic [31:0] BASE       = 32'hF4000000;

  typedef struct {
    int klen; int dlen; int done_poll; int rlen;
    int in_gap; int out_gap; int exp_reads; bit exp_err;
  } job_t;

  logic clk = 1'b0, rst_i = 1'b1;
  logic start_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [10:0] key_len_i = '0, data_len_i = '0;
  logic [31:0] in_data_i = '0, bus_data_i = '0;
  logic in_ready_o, out_valid_o, out_last_o, busy_o, done_o, err_o;
  logic bus_read_en_o, bus_write_en_o;
  logic [31:0] out_data_o, bus_addr_o, bus_data_o;
  logic [3:0] dbg_state_o;

  crypto_acc_host_master #(.POLL_GAP(POLL_GAP), .POLL_LIMIT(POLL_LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .key_len_i(key_len_i),
    .data_len_i(data_len_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .bus_read_en_o(bus_read_en_o), .bus_write_en_o(bus_write_en_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [64:0] exp_q[$];
  logic [32:0] exp_out_q[$];
  logic [31:0] feed_q[$];
  int checks = 0, failures = 0;
  int done_seen = 0, err_seen = 0, res_reads = 0;
  int last_stat_cyc = -1;
  bit job_over = 1'b0;
  int cfg_done_poll = 1, cfg_rlen = 0;
  logic [31:0] cfg_seed = 32'h0;
  int status_reads = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] res_word(input logic [31:0] seed, input int i);
    return seed ^ (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [64:0] op_w(input logic [31:0] off, input logic [31:0] d);
    return {1'b0, BASE + off, d};
  endfunction
  function automatic logic [64:0] op_r(input logic [31:0] off);
    return {1'b1, BASE + off, 32'h0};
  endfunction

  // accelerator slave: read data valid exactly one cycle after the strobe, garbage otherwise
  always @(posedge clk) begin
    if (bus_write_en_o && bus_addr_o == BASE) status_reads <= 0;
    if (bus_read_en_o) begin
      if (bus_addr_o == BASE + 32'h8) begin
        bus_data_i <= ($urandom & 32'hFFFF_FFFE) |
                      32'((cfg_done_poll != 0) && (status_reads + 1 >= cfg_done_poll));
        status_reads <= status_reads + 1;
      end else if (bus_addr_o == BASE + 32'h10C) begin
        bus_data_i <= 32'(cfg_rlen);
      end else if (bus_addr_o >= BASE + 32'hC000 && bus_addr_o < BASE + 32'h10000) begin
        bus_data_i <= res_word(cfg_seed, int'((bus_addr_o - BASE - 32'hC000) >> 2));
      end else begin
        bus_data_i <= 32'hDEADBEEF;
      end
    end else begin
      bus_data_i <= $urandom;
    end
  end

  // monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus_read_en_o && bus_write_en_o) check("strobe_exclusive", 1, 0);
    if (bus_read_en_o || bus_write_en_o) begin
      if (exp_q.size() == 0) begin
        check("bus_extra", {bus_read_en_o, bus_addr_o, bus_data_o}, 0);
      end else begin
        check("bus_op", {bus_read_en_o, bus_addr_o, bus_write_en_o ? bus_data_o : 32'h0},
              exp_q.pop_front());
      end
      if (bus_write_en_o && bus_addr_o == BASE) last_stat_cyc = -1;
      if (bus_read_en_o && bus_addr_o == BASE + 32'h8) begin
        if (last_stat_cyc >= 0) check("poll_spacing", cyc - last_stat_cyc, POLL_GAP + 2);
        last_stat_cyc = cyc;
      end
      if (bus_read_en_o && bus_addr_o >= BASE + 32'hC000 && bus_addr_o < BASE + 32'h10000)
        res_reads++;
    end
    if (out_valid_o && out_ready_i) begin
      if (exp_out_q.size() == 0) check("out_extra", {out_last_o, out_data_o}, 0);
      else check("out_word", {out_last_o, out_data_o}, exp_out_q.pop_front());
    end
    if (done_o) begin
      done_seen++;
      check("busy_at_done", busy_o, 0);
    end
    if (err_o) begin
      err_seen++;
      check("busy_at_err", busy_o, 0);
    end
  end

  // driver tasks
  task automatic feed_words(input int gap);
    bit hs;
    int guard;
    while (feed_q.size() > 0) begin
      if ($urandom_range(99) < gap) begin
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        continue;
      end
      in_valid_i = 1'b1;
      in_data_i  = feed_q[0];
      guard = 0;
      hs = 1'b0;
      while (!hs && guard < 2000) begin
        @(negedge clk); hs = in_ready_o;
        @(posedge clk); #1;
        guard++;
      end
      if (!hs) begin
        check("feed_stall", guard, 0);
        feed_q.delete();
      end else begin
        void'(feed_q.pop_front());
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic drive_out(input int gap);
    while (!job_over) begin
      out_ready_i = ($urandom_range(99) >= gap);
      @(posedge clk); #1;
    end
    out_ready_i = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0);
    int guard = 0;
    repeat (2) @(posedge clk);
    #1;
    start_i = 1'b1; key_len_i = 11'd7; data_len_i = 11'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    while (done_seen == d0 && err_seen == e0 && guard < 30000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 30000) check("job_timeout", guard, 0);
    repeat (2) @(posedge clk);
    #1;
    job_over = 1'b1;
  endtask

  task automatic run_job(input job_t j);
    logic [31:0] w;
    int nres, d0, e0, r0;
    exp_q.delete(); exp_out_q.delete(); feed_q.delete();
    cfg_done_poll = j.done_poll; cfg_rlen = j.rlen; cfg_seed = $urandom;
    exp_q.push_back(op_w(32'h104, 32'(j.klen)));
    for (int i = 0; i < j.klen; i++) begin
      w = $urandom; feed_q.push_back(w);
      exp_q.push_back(op_w(32'h4000 + 32'(i) * 4, w));
    end
    exp_q.push_back(op_w(32'h108, 32'(j.dlen)));
    for (int i = 0; i < j.dlen; i++) begin
      w = $urandom; feed_q.push_back(w);
      exp_q.push_back(op_w(32'h8000 + 32'(i) * 4, w));
    end
    exp_q.push_back(op_w(32'h0, 32'h1));
    if (j.exp_err) begin
      for (int p = 0; p < POLL_LIMIT; p++) exp_q.push_back(op_r(32'h8));
      exp_q.push_back(op_w(32'h0, 32'h0));
    end else begin
      for (int p = 0; p < j.done_poll; p++) exp_q.push_back(op_r(32'h8));
      exp_q.push_back(op_r(32'h10C));
      nres = (j.rlen > 1024) ? 1024 : j.rlen;
      for (int i = 0; i < nres; i++) begin
        exp_q.push_back(op_r(32'hC000 + 32'(i) * 4));
        exp_out_q.push_back({i == nres - 1, res_word(cfg_seed, i)});
      end
    end
    d0 = done_seen; e0 = err_seen; r0 = res_reads; job_over = 1'b0;
    key_len_i = 11'(j.klen); data_len_i = 11'(j.dlen); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    fork
      feed_words(j.in_gap);
      drive_out(j.out_gap);
      wait_end(d0, e0);
    join
    check("bus_ops_left", exp_q.size(), 0);
    check("out_words_left", exp_out_q.size(), 0);
    check("done_pulses", done_seen - d0, j.exp_err ? 0 : 1);
    check("err_pulses", err_seen - e0, j.exp_err ? 1 : 0);
    check("result_reads", res_reads - r0, j.exp_reads);
    check("idle_after_job", {busy_o, dbg_state_o}, 0);
  endtask

  // main sequence
  job_t jobs[6];
  job_t rj;
  logic [31:0] k0, k1;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy_o, done_o, err_o, in_ready_o, out_valid_o, out_last_o,
          bus_read_en_o, bus_write_en_o, dbg_state_o, bus_addr_o, bus_data_o, out_data_o}, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    jobs[0] = '{4, 8, 3, 8, 0, 0, 8, 1'b0};
    jobs[1] = '{0, 2, 1, 3, 0, 0, 3, 1'b0};
    jobs[2] = '{3, 0, 2, 1, 0, 0, 1, 1'b0};
    jobs[3] = '{0, 0, 1, 0, 0, 0, 0, 1'b0};
    jobs[4] = '{2, 2, 1, 32'h800, 0, 0, 1024, 1'b0};
    jobs[5] = '{5, 6, 4, 5, 40, 50, 5, 1'b0};
    for (int t = 0; t < 6; t++) run_job(jobs[t]);

    for (int r = 0; r < 6; r++) begin
      rj.klen = $urandom_range(0, 10); rj.dlen = $urandom_range(0, 10);
      rj.done_poll = $urandom_range(1, 5); rj.rlen = $urandom_range(0, 12);
      rj.in_gap = $urandom_range(0, 60); rj.out_gap = $urandom_range(0, 60);
      rj.exp_reads = rj.rlen; rj.exp_err = 1'b0;
      run_job(rj);
    end

`ifdef CRYPTO_HOST_POLL_TIMEOUT_EN
    rj = '{2, 1, 0, 5, 0, 0, 0, 1'b1};
    run_job(rj);
`endif

    // asynchronous reset in the middle of the key phase
    exp_q.delete(); exp_out_q.delete();
    k0 = $urandom; k1 = $urandom;
    exp_q.push_back(op_w(32'h104, 32'd4));
    exp_q.push_back(op_w(32'h4000, k0));
    exp_q.push_back(op_w(32'h4004, k1));
    key_len_i = 11'd4; data_len_i = 11'd4; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; in_valid_i = 1'b1; in_data_i = k0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_data_i = k1;
    @(posedge clk); #1;
    in_data_i = $urandom;
    check("busy_before_reset", busy_o, 1);
    #1 rst_i = 1'b1;
    #1;
    check("async_reset_outputs", {busy_o, done_o, err_o, in_ready_o, out_valid_o, out_last_o,
          bus_read_en_o, bus_write_en_o, dbg_state_o, bus_addr_o, bus_data_o}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ops_consumed", exp_q.size(), 0);
    rst_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    check("idle_after_reset", {busy_o, in_ready_o, dbg_state_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
